dual_issue_hazard_ctrl: RTL
===========================

# dual_issue_hazard_ctrl

Hazard and issue controller for the two-lane (A = older, B = younger) in-order pipeline, sitting between the decode stage and the ID/EX pipeline register. Each cycle it compares the decoded bundle's source registers against the destinations in flight in EX and MEM. It produces registered forwarding selects and per-lane hazard codes of type `hazard_signal_t`. It also sequences split issue and load-use bubbles with a three-state FSM, and drives the fetch/decode hold.

## Interface
- `REG_AW`, 5: register-address width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  branch/jump redirect; kills the bundle in ID.
- `id_valid_a`, `id_valid_b`  in  1 each  lane holds a real instruction.
- `id_rs1_a`, `id_rs2_a`, `id_rd_a`, `id_rs1_b`, `id_rs2_b`, `id_rd_b`  in  REG_AW each  decoded register fields.
- `id_use_rs1_a`, `id_use_rs2_a`, `id_use_rs1_b`, `id_use_rs2_b`  in  1 each  operand is actually read.
- `id_regwrite_a`, `id_regwrite_b`  in  1 each  lane writes rd.
- `ex_rd_a`, `ex_rd_b`, `mem_rd_a`, `mem_rd_b`  in  REG_AW each  destinations in EX and MEM.
- `ex_regwrite_a`, `ex_regwrite_b`, `mem_regwrite_a`, `mem_regwrite_b`  in  1 each.
- `ex_memread_a`, `ex_memread_b`  in  1 each  EX lane is a load.
- `hold_id`  out  1  combinational; fetch and ID must not advance.
- `issue_a`, `issue_b`  out  1 each  registered; lane enters ID/EX valid.
- `hz_a`, `hz_b`  out  4 each  registered `hazard_signal_t` status.
- `fwd_rs1_a`, `fwd_rs2_a`, `fwd_rs1_b`, `fwd_rs2_b`  out  4 each  registered `hazard_signal_t` forward select.

## Operation
- Encoding (package): A_STALL=0, B_STALL=1, STALL_FROM_A=2, STALL_FROM_B=3, EX_MEM_A=4, EX_MEM_B=5, MEM_WB_A=6, MEM_WB_B=7, FORW_FROM_A=8, NONE_h=9.
- Match rule: an operand matches a producer when `use` is set, the producer's `regwrite` is set, the rd values are equal, and rd ≠ 0.
- Forward select for each operand, in priority order:
  - EX lane B → EX_MEM_B.
  - EX lane A → EX_MEM_A.
  - MEM lane B → MEM_WB_B.
  - MEM lane A → MEM_WB_A.
  - Otherwise NONE_h.
- Load-use: any issuing operand that matches an EX producer whose `memread` is set.
- Intra-bundle dependency: B rs1 or rs2 matches A's rd (with `id_regwrite_a`), and both lanes are valid.
- FSM states:
  - **RUN**
    - Load-use on either lane: bubble both lanes, `hz` = A_STALL / B_STALL for the offending lane(s), `hold_id`=1, go to LOAD_WAIT.
    - Else intra-dependency: issue A only, `hz_b`=STALL_FROM_A, `hold_id`=1, go to SPLIT.
    - Else issue both, `hz`=NONE_h.
  - **LOAD_WAIT**: lasts exactly one cycle; re-evaluates the same bundle as RUN does. The load is now in MEM, so forwarding resolves to MEM_WB_x.
  - **SPLIT**: lane A is ignored. B issues with `issue_a`=0 and `hz_b`=FORW_FROM_A; its forward select comes from the normal rule (typically EX_MEM_A). If B has load-use on A, emit a bubble (`hz_b`=B_STALL), keep `hold_id`=1, and stay in SPLIT. Return to RUN when B issues.
- Invalid lanes never stall, never forward, and produce `issue`=0 with `hz`=NONE_h.
- Flush (any state): next state RUN; next `issue_a`/`issue_b`=0, all codes NONE_h; `hold_id`=0 that cycle.
- Flush has priority over stall. Stall has priority over split.

## Timing
- Reset, on `clk` with `rst_n`=0: state RUN; `issue_*`=0; all `hz_*`/`fwd_*`=NONE_h (9); `hold_id`=0 while `rst_n`=0.
- Latency: `issue`, `hz`, and `fwd` are registered one cycle after the ID inputs are sampled, aligned with the ID/EX register.
- `hold_id` is valid in the same cycle as its ID inputs.
- Load-use costs 1 bubble cycle. Intra-bundle split costs 1 extra cycle. A split followed by load-use costs 2 cycles.
- Reset asserted mid-SPLIT or mid-LOAD_WAIT aborts to RUN with the reset values above, taking effect on the next edge.

## Structure
- Add `issue_state_t {RUN, LOAD_WAIT, SPLIT}` to the shared enum package beside `hazard_signal_t`; reuse `slv_to_hazE` for waveform decode.
- Sub-module `fwd_sel`: a combinational single-operand priority comparator, instantiated 4×.
- Top level holds the FSM and the output registers.

## Test plan
- Independent bundle, A=add x5, B=sub x6, no EX/MEM matches → `issue_a`=`issue_b`=1, all codes 9, `hold_id`=0.
- EX lane B load x7, ID lane A reads x7 → cycle 1: bubble, `hz_a`=0, `hold_id`=1. Cycle 2: issue both, `fwd_rs1_a`=MEM_WB_B (7).
- Bundle A writes x3, B reads x3 → cycle 1: `issue_a`=1, `issue_b`=0, `hz_b`=2. Cycle 2: `issue_b`=1, `hz_b`=8, `fwd_rs*_b`=EX_MEM_A (4).
- x9 written in both EX lane A and MEM lane B, ID reads x9 → forward select EX_MEM_A (4). Same test with rd=x0 → NONE_h (9).
- `flush` asserted while in SPLIT → next cycle `issue_*`=0, codes 9, state RUN; `rst_n` low mid-LOAD_WAIT → reset values on the next edge.

Source files
------------

// File: rtl/dual_issue_hazard_ctrl_pkg.sv
// Shared encodings for the dual-issue hazard controller: hazard/forward codes
// and issue FSM states.
package dual_issue_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    A_STALL      = 4'd0,
    B_STALL      = 4'd1,
    STALL_FROM_A = 4'd2,
    STALL_FROM_B = 4'd3,
    EX_MEM_A     = 4'd4,
    EX_MEM_B     = 4'd5,
    MEM_WB_A     = 4'd6,
    MEM_WB_B     = 4'd7,
    FORW_FROM_A  = 4'd8,
    NONE_h       = 4'd9
  } hazard_signal_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    SPLIT     = 2'd2
  } issue_state_t;

  // Waveform helper: codes outside the defined range decode as NONE_h.
  function automatic hazard_signal_t slv_to_hazE(input logic [3:0] v);
    return (v > 4'd9) ? NONE_h : hazard_signal_t'(v);
  endfunction

endpackage

// File: rtl/dual_issue_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding priority comparator; also flags a load-use match
// against the EX stage.
module dual_issue_hazard_ctrl_fwd_sel
  import dual_issue_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              use_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] ex_rd_a_i,
  input  logic [REG_AW-1:0] ex_rd_b_i,
  input  logic [REG_AW-1:0] mem_rd_a_i,
  input  logic [REG_AW-1:0] mem_rd_b_i,
  input  logic              ex_regwrite_a_i,
  input  logic              ex_regwrite_b_i,
  input  logic              mem_regwrite_a_i,
  input  logic              mem_regwrite_b_i,
  input  logic              ex_memread_a_i,
  input  logic              ex_memread_b_i,
  output hazard_signal_t    sel_o,
  output logic              load_use_o
);

  logic live;
  logic ex_a_hit, ex_b_hit, mem_a_hit, mem_b_hit;

  // x0 is never a real producer, so a zero source cannot match anything.
  assign live      = use_i && (rs_i != '0);
  assign ex_b_hit  = live && ex_regwrite_b_i  && (ex_rd_b_i  == rs_i);
  assign ex_a_hit  = live && ex_regwrite_a_i  && (ex_rd_a_i  == rs_i);
  assign mem_b_hit = live && mem_regwrite_b_i && (mem_rd_b_i == rs_i);
  assign mem_a_hit = live && mem_regwrite_a_i && (mem_rd_a_i == rs_i);

  assign load_use_o = (ex_b_hit && ex_memread_b_i) || (ex_a_hit && ex_memread_a_i);

  always_comb begin
    sel_o = NONE_h;
    if (ex_b_hit)       sel_o = EX_MEM_B;
    else if (ex_a_hit)  sel_o = EX_MEM_A;
    else if (mem_b_hit) sel_o = MEM_WB_B;
    else if (mem_a_hit) sel_o = MEM_WB_A;
  end

endmodule

// File: rtl/dual_issue_hazard_ctrl.sv
// Dual-lane hazard/issue controller: load-use bubbles, intra-bundle split issue
// and registered forwarding selects feeding the ID/EX register.
module dual_issue_hazard_ctrl
  import dual_issue_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid_a,
  input  logic              id_valid_b,
  input  logic [REG_AW-1:0] id_rs1_a,
  input  logic [REG_AW-1:0] id_rs2_a,
  input  logic [REG_AW-1:0] id_rd_a,
  input  logic [REG_AW-1:0] id_rs1_b,
  input  logic [REG_AW-1:0] id_rs2_b,
  input  logic [REG_AW-1:0] id_rd_b,
  input  logic              id_use_rs1_a,
  input  logic              id_use_rs2_a,
  input  logic              id_use_rs1_b,
  input  logic              id_use_rs2_b,
  input  logic              id_regwrite_a,
  input  logic              id_regwrite_b,
  input  logic [REG_AW-1:0] ex_rd_a,
  input  logic [REG_AW-1:0] ex_rd_b,
  input  logic [REG_AW-1:0] mem_rd_a,
  input  logic [REG_AW-1:0] mem_rd_b,
  input  logic              ex_regwrite_a,
  input  logic              ex_regwrite_b,
  input  logic              mem_regwrite_a,
  input  logic              mem_regwrite_b,
  input  logic              ex_memread_a,
  input  logic              ex_memread_b,
  output logic              hold_id,
  output logic              issue_a,
  output logic              issue_b,
  output hazard_signal_t    hz_a,
  output hazard_signal_t    hz_b,
  output hazard_signal_t    fwd_rs1_a,
  output hazard_signal_t    fwd_rs2_a,
  output hazard_signal_t    fwd_rs1_b,
  output hazard_signal_t    fwd_rs2_b
);

  issue_state_t   state_q, state_d;
  logic           issue_a_q, issue_a_d, issue_b_q, issue_b_d;
  hazard_signal_t hz_a_q, hz_a_d, hz_b_q, hz_b_d;
  hazard_signal_t fwd_rs1_a_q, fwd_rs1_a_d, fwd_rs2_a_q, fwd_rs2_a_d;
  hazard_signal_t fwd_rs1_b_q, fwd_rs1_b_d, fwd_rs2_b_q, fwd_rs2_b_d;
  logic           hold_d;

  logic [REG_AW-1:0] op_rs  [4];
  logic              op_use [4];
  hazard_signal_t    op_sel [4];
  logic              op_lu  [4];
  logic              lu_a, lu_b, intra;
  logic              unused_b_dest;

  // Lane B's own destination only matters once it reaches EX/MEM.
  assign unused_b_dest = ^{id_rd_b, id_regwrite_b};

  assign op_rs[0]  = id_rs1_a;
  assign op_rs[1]  = id_rs2_a;
  assign op_rs[2]  = id_rs1_b;
  assign op_rs[3]  = id_rs2_b;
  assign op_use[0] = id_valid_a && id_use_rs1_a;
  assign op_use[1] = id_valid_a && id_use_rs2_a;
  assign op_use[2] = id_valid_b && id_use_rs1_b;
  assign op_use[3] = id_valid_b && id_use_rs2_b;

  for (genvar g = 0; g < 4; g++) begin : g_fwd
    dual_issue_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
      .use_i            (op_use[g]),
      .rs_i             (op_rs[g]),
      .ex_rd_a_i        (ex_rd_a),
      .ex_rd_b_i        (ex_rd_b),
      .mem_rd_a_i       (mem_rd_a),
      .mem_rd_b_i       (mem_rd_b),
      .ex_regwrite_a_i  (ex_regwrite_a),
      .ex_regwrite_b_i  (ex_regwrite_b),
      .mem_regwrite_a_i (mem_regwrite_a),
      .mem_regwrite_b_i (mem_regwrite_b),
      .ex_memread_a_i   (ex_memread_a),
      .ex_memread_b_i   (ex_memread_b),
      .sel_o            (op_sel[g]),
      .load_use_o       (op_lu[g])
    );
  end

  assign lu_a  = op_lu[0] || op_lu[1];
  assign lu_b  = op_lu[2] || op_lu[3];
  assign intra = id_valid_a && id_valid_b && id_regwrite_a && (id_rd_a != '0) &&
                 ((op_use[2] && (id_rs1_b == id_rd_a)) || (op_use[3] && (id_rs2_b == id_rd_a)));

  always_comb begin
    state_d     = state_q;
    issue_a_d   = 1'b0;
    issue_b_d   = 1'b0;
    hz_a_d      = NONE_h;
    hz_b_d      = NONE_h;
    fwd_rs1_a_d = NONE_h;
    fwd_rs2_a_d = NONE_h;
    fwd_rs1_b_d = NONE_h;
    fwd_rs2_b_d = NONE_h;
    hold_d      = 1'b0;
    if (flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        SPLIT: begin
          if (lu_b) begin
            hz_b_d = B_STALL;
            hold_d = 1'b1;
          end else begin
            issue_b_d   = id_valid_b;
            hz_b_d      = id_valid_b ? FORW_FROM_A : NONE_h;
            fwd_rs1_b_d = op_sel[2];
            fwd_rs2_b_d = op_sel[3];
            state_d     = RUN;
          end
        end
        default: begin
          // LOAD_WAIT re-evaluates the held bundle exactly as RUN does.
          if (lu_a || lu_b) begin
            hz_a_d  = lu_a ? A_STALL : NONE_h;
            hz_b_d  = lu_b ? B_STALL : NONE_h;
            hold_d  = 1'b1;
            state_d = LOAD_WAIT;
          end else if (intra) begin
            issue_a_d   = 1'b1;
            fwd_rs1_a_d = op_sel[0];
            fwd_rs2_a_d = op_sel[1];
            hz_b_d      = STALL_FROM_A;
            hold_d      = 1'b1;
            state_d     = SPLIT;
          end else begin
            issue_a_d   = id_valid_a;
            issue_b_d   = id_valid_b;
            fwd_rs1_a_d = op_sel[0];
            fwd_rs2_a_d = op_sel[1];
            fwd_rs1_b_d = op_sel[2];
            fwd_rs2_b_d = op_sel[3];
            state_d     = RUN;
          end
        end
      endcase
    end
  end

  assign hold_id = rst_n && hold_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      issue_a_q   <= 1'b0;
      issue_b_q   <= 1'b0;
      hz_a_q      <= NONE_h;
      hz_b_q      <= NONE_h;
      fwd_rs1_a_q <= NONE_h;
      fwd_rs2_a_q <= NONE_h;
      fwd_rs1_b_q <= NONE_h;
      fwd_rs2_b_q <= NONE_h;
    end else begin
      state_q     <= state_d;
      issue_a_q   <= issue_a_d;
      issue_b_q   <= issue_b_d;
      hz_a_q      <= hz_a_d;
      hz_b_q      <= hz_b_d;
      fwd_rs1_a_q <= fwd_rs1_a_d;
      fwd_rs2_a_q <= fwd_rs2_a_d;
      fwd_rs1_b_q <= fwd_rs1_b_d;
      fwd_rs2_b_q <= fwd_rs2_b_d;
    end
  end

  assign issue_a   = issue_a_q;
  assign issue_b   = issue_b_q;
  assign hz_a      = hz_a_q;
  assign hz_b      = hz_b_q;
  assign fwd_rs1_a = fwd_rs1_a_q;
  assign fwd_rs2_a = fwd_rs2_a_q;
  assign fwd_rs1_b = fwd_rs1_b_q;
  assign fwd_rs2_b = fwd_rs2_b_q;

endmodule
